regfile_wb_sched: RTL
=====================

# regfile_wb_sched

Write-back scheduler for the 32x32 register file. It shares the register file's single write port (rd, wr, Din) between two write-back requesters, source 0 (ALU) and source 1 (load unit). Each source has a small FIFO. The block arbitrates round-robin between FIFO heads and drives one registered write per cycle. It also exports a pending-write scoreboard that hazard logic uses to stall reads of registers with uncommitted writes.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- DEPTH, 2, entries per source FIFO (power of two, at least 2)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset; clears all state immediately
- s0_valid  in  1  source 0 write request
- s0_ready  out  1  source 0 FIFO can accept
- s0_rd  in  ADDR_W  source 0 destination register
- s0_data  in  DATA_W  source 0 write data
- s1_valid, s1_ready, s1_rd, s1_data  same as source 0, for source 1
- rf_wr  out  1  register file write enable
- rf_rd  out  ADDR_W  register file write address
- rf_din  out  DATA_W  register file write data
- busy  out  2**ADDR_W  bit i is set while a write to register i is queued or issued but not yet committed

## Operation
- Handshake:
  - A request is accepted on a rising edge where sX_valid and sX_ready are both 1.
  - sX_ready = (FIFO X not full) AND reset. It is driven low while reset is asserted.
  - Full status comes from the registered count only. A dequeue in the same cycle does not raise ready.
- Register 0:
  - A request with rd = 0 is accepted under the normal handshake and then discarded. It is never enqueued and never drives rf_wr.
  - busy[0] is always 0.
- FIFOs:
  - One per source, in-order.
  - Count range is 0..DEPTH; read and write pointers wrap modulo DEPTH.
  - A simultaneous enqueue and dequeue on a full FIFO cannot occur, because ready is low when full.
  - On a non-full FIFO, a simultaneous enqueue and dequeue leaves the count unchanged.
- Arbitration (state `last`, 1 bit; reset value 1, so source 0 wins first):
  - Only one head non-empty: grant that source.
  - Both heads non-empty: grant source (~last).
  - On any grant, `last` takes the granted source.
  - Neither non-empty: no grant, and `last` holds.
- Output stage (registered):
  - On a grant, rf_wr <= 1 and rf_rd/rf_din <= the head entry, and the head is popped.
  - With no grant, rf_wr <= 0 and rf_rd/rf_din hold their values.
- busy[i] = OR over all valid FIFO entries with rd == i, OR (rf_wr AND rf_rd == i). It is combinational from state.
- Ordering:
  - Writes from one source commit in acceptance order.
  - Relative order of writes from different sources to the same rd is not guaranteed. Upstream logic must check busy before issuing a second writer to the same register.

## Timing
- Reset values: rf_wr=0, rf_rd=0, rf_din=0, busy=0, s0_ready=s1_ready=0 while reset is low, both FIFOs empty, last=1.
- After reset is released, both ready outputs are 1.
- Uncontested latency:
  - Request accepted at edge E.
  - Granted in the cycle after E.
  - rf_wr is high in the cycle after edge E+1.
  - The register file commits at edge E+2.
- Contested latency: the losing head waits one additional cycle per earlier grant.
- Throughput: one write per cycle sustained, alternating between sources when both are backlogged.
- busy[rd] is set from the cycle after acceptance edge E through the cycle in which rf_wr is high. It clears after commit edge E+2, unless another pending entry targets the same register.
- Reset asserted mid-operation: all queued and issued-but-uncommitted writes are dropped, and rf_wr falls to 0 asynchronously.

## Structure
- Shared package: DATA_W/ADDR_W defaults, number of registers (2**ADDR_W), and source index constants SRC_ALU=0, SRC_LD=1.
- Sub-module wb_fifo: parameterised by DEPTH and entry width, with push/pop, full/empty, and entry-valid plus rd exposure for busy. Instantiate it twice.
- The top level holds the arbiter, the `last` register, the output register, and the busy reduction.

## Test plan
- Reset, then s0 writes rd=3, data=0xDEADBEEF at edge E -> rf_wr=1, rf_rd=3, rf_din=0xDEADBEEF in the cycle after E+1. busy[3]=1 over that span, then 0.
- Both sources valid every cycle (s0 rd=1.., s1 rd=17..) -> grants alternate s0, s1, s0, s1, … starting with s0. One rf_wr per cycle, with no drops or duplicates.
- Hold rf-side consumption busy with s1 backlogged and s0 pushing 3 entries with DEPTH=2 -> s0_ready drops after 2 accepts and the third waits. All three commit in order.
- s0 request with rd=0, data=0x1234 -> accepted (s0_ready=1), rf_wr stays 0, busy stays 0.
- Two queued s1 writes to rd=5 -> busy[5] stays 1 until the second commits. Final rf_din reflects the second write.
- Assert reset with both FIFOs holding entries and rf_wr=1 -> rf_wr and busy go to 0 immediately. After release, no write from the flushed entries ever appears.

Source files
------------

// File: rtl/regfile_wb_sched_pkg.sv
// regfile_wb_sched_pkg: shared sizes and source indices for the register-file write-back scheduler
package regfile_wb_sched_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 2**ADDR_W_DEF;
    localparam bit SRC_ALU    = 1'b0;
    localparam bit SRC_LD     = 1'b1;
endpackage

// File: rtl/regfile_wb_sched_fifo.sv
// wb_fifo: in-order write-back queue; entries are {rd, data} with rd in the top RD_W bits
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37,
    parameter int RD_W  = 5
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [W-1:0]                   din,
    output logic [W-1:0]                   dout,
    output logic                           full,
    output logic                           empty,
    output logic [DEPTH-1:0]               ent_valid,
    output logic [DEPTH-1:0][RD_W-1:0]     ent_rd
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] cnt;

    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign dout  = mem[rptr];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop) rptr <= rptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wptr] <= din;
    end

    // an entry is live when its distance from the read pointer is below the count
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off          = PW'(i) - rptr;
        assign ent_valid[i] = CW'(off) < cnt;
        assign ent_rd[i]    = mem[i][W-1 -: RD_W];
    end
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: round-robin write-back arbiter for two sources sharing the register file write port,
// with a pending-write scoreboard for hazard stalls
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [ADDR_W-1:0]     s0_rd,
    input  logic [DATA_W-1:0]     s0_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [ADDR_W-1:0]     s1_rd,
    input  logic [DATA_W-1:0]     s1_data,
    output logic                  rf_wr,
    output logic [ADDR_W-1:0]     rf_rd,
    output logic [DATA_W-1:0]     rf_din,
    output logic [2**ADDR_W-1:0]  busy
);
    localparam int W = ADDR_W + DATA_W;

    logic [W-1:0]                   h0, h1, hd;
    logic                           full0, full1, e0, e1;
    logic                           push0, push1, pop0, pop1;
    logic                           gnt, sel, last;
    logic [DEPTH-1:0]               v0, v1;
    logic [DEPTH-1:0][ADDR_W-1:0]   r0, r1;

    assign s0_ready = ~full0 & reset;
    assign s1_ready = ~full1 & reset;
    // writes to r0 complete the handshake but are dropped before the queue
    assign push0 = s0_valid & s0_ready & (s0_rd != '0);
    assign push1 = s1_valid & s1_ready & (s1_rd != '0);

    assign gnt  = ~e0 | ~e1;
    assign sel  = e0 ? SRC_LD : e1 ? SRC_ALU : ~last;
    assign pop0 = gnt & (sel == SRC_ALU);
    assign pop1 = gnt & (sel == SRC_LD);
    assign hd   = sel ? h1 : h0;

    wb_fifo #(.DEPTH(DEPTH), .W(W), .RD_W(ADDR_W)) u_fifo0 (
        .CLK(CLK), .reset(reset), .push(push0), .pop(pop0), .din({s0_rd, s0_data}),
        .dout(h0), .full(full0), .empty(e0), .ent_valid(v0), .ent_rd(r0)
    );

    wb_fifo #(.DEPTH(DEPTH), .W(W), .RD_W(ADDR_W)) u_fifo1 (
        .CLK(CLK), .reset(reset), .push(push1), .pop(pop1), .din({s1_rd, s1_data}),
        .dout(h1), .full(full1), .empty(e1), .ent_valid(v1), .ent_rd(r1)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rf_wr  <= 1'b0;
            rf_rd  <= '0;
            rf_din <= '0;
            last   <= 1'b1;
        end else begin
            rf_wr <= gnt;
            if (gnt) begin
                last            <= sel;
                {rf_rd, rf_din} <= hd;
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (v0[i]) busy[r0[i]] = 1'b1;
            if (v1[i]) busy[r1[i]] = 1'b1;
        end
        if (rf_wr) busy[rf_rd] = 1'b1;
        busy[0] = 1'b0;
    end
endmodule
